// File: rtl/segment_recorder.sv
// segment_recorder: steers a qualified byte stream into up to four segment
// buffers of fixed length. A one-hot write strobe selects the buffer; the
// block can stop after one segment or rotate through the enabled segments.
// Arm low aborts a capture immediately and drops any pending write.
module segment_recorder #(
    parameter int LEN0 = 132,
    parameter int LEN1 = 121,
    parameter int LEN2 = 88,
    parameter int LEN3 = 55
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       arm,
    input  logic       auto_mode,
    input  logic [3:0] ch_en,
    input  logic       sample_valid,
    input  logic [7:0] sample_in,
    output logic [3:0] wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [1:0] active_ch,
    output logic       busy,
    output logic       seg_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Terminal address of each segment (segment length minus one)
    localparam logic [7:0] LAST0 = 8'(LEN0 - 1);
    localparam logic [7:0] LAST1 = 8'(LEN1 - 1);
    localparam logic [7:0] LAST2 = 8'(LEN2 - 1);
    localparam logic [7:0] LAST3 = 8'(LEN3 - 1);

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic       terminal;

    function automatic logic [7:0] last_of(input logic [1:0] ch);
        logic [7:0] r;
        case (ch)
            2'd0:    r = LAST0;
            2'd1:    r = LAST1;
            2'd2:    r = LAST2;
            default: r = LAST3;
        endcase
        return r;
    endfunction

    // Lowest-index enabled segment; scanning downward leaves the lowest set bit
    function automatic logic [1:0] lowest_en(input logic [3:0] en);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (en[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Round-robin successor: cur+1, cur+2, cur+3, then cur itself.
    // Scanning from the farthest offset down so the nearest enabled one wins.
    function automatic logic [1:0] next_en(input logic [1:0] cur, input logic [3:0] en);
        logic [1:0] r;
        logic [1:0] idx;
        r = cur;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + k[1:0];
            if (en[idx]) r = idx;
        end
        return r;
    endfunction

    assign terminal = (cnt_reg == last_of(active_ch));

    // Capture FSM with registered write port, status and segment tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            wr_en     <= 4'd0;
            wr_addr   <= 8'd0;
            wr_data   <= 8'd0;
            active_ch <= 2'd0;
            busy      <= 1'b0;
            seg_done  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            wr_en    <= 4'd0;
            seg_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arm && (ch_en != 4'd0)) begin
                        active_ch <= lowest_en(ch_en);
                        cnt_reg   <= 8'd0;
                        state_reg <= CAPTURE;
                        busy      <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!arm) begin
                        // Abort wins over any sample this cycle, including terminal
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        cnt_reg   <= 8'd0;
                    end else if (sample_valid) begin
                        wr_en   <= 4'b0001 << active_ch;
                        wr_addr <= cnt_reg;
                        wr_data <= sample_in;
                        if (terminal) begin
                            seg_done <= 1'b1;
                            cnt_reg  <= 8'd0;
                            if (auto_mode && (ch_en != 4'd0)) begin
                                active_ch <= next_en(active_ch, ch_en);
                            end else begin
                                state_reg <= HOLD;
                                busy      <= 1'b0;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    // Wait for arm to drop so a steady arm cannot re-trigger
                    if (!arm) state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segment_recorder.sv
// tb_segment_recorder: directed scenarios followed by random traffic, all
// checked cycle by cycle against a sample-count reference model.
module tb_segment_recorder;

    localparam int L0 = 132;
    localparam int L1 = 121;
    localparam int L2 = 88;
    localparam int L3 = 55;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       arm = 1'b0;
    logic       auto_mode = 1'b0;
    logic [3:0] ch_en = 4'd0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_in = 8'd0;
    logic [3:0] wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] active_ch;
    logic       busy;
    logic       seg_done;

    int total = 0;
    int bad = 0;

    segment_recorder #(.LEN0(L0), .LEN1(L1), .LEN2(L2), .LEN3(L3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .arm(arm),
        .auto_mode(auto_mode),
        .ch_en(ch_en),
        .sample_valid(sample_valid),
        .sample_in(sample_in),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .active_ch(active_ch),
        .busy(busy),
        .seg_done(seg_done)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 recording, 2 waiting for arm release.
    // m_pos counts samples already stored in the current segment.
    int len_tab[4] = '{L0, L1, L2, L3};
    int m_mode = 0;
    int m_seg = 0;
    int m_pos = 0;
    logic [3:0] e_wr_en;
    int e_addr;
    int e_data;
    logic e_done;

    // Per-scenario tallies
    int n_done;
    logic [3:0] wr_mask;
    int addr_log[$];
    int done_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int nxt;
        e_wr_en = 4'd0;
        e_done = 1'b0;
        if (!reset_n) begin
            m_mode = 0;
            m_seg = 0;
            m_pos = 0;
            return;
        end
        case (m_mode)
            0: begin
                if (arm && ch_en != 4'd0) begin
                    for (int i = 3; i >= 0; i--) if (ch_en[i]) m_seg = i;
                    m_pos = 0;
                    m_mode = 1;
                end
            end
            1: begin
                if (!arm) begin
                    m_mode = 0;
                    m_pos = 0;
                end else if (sample_valid) begin
                    e_wr_en = 4'(1 << m_seg);
                    e_addr = m_pos;
                    e_data = int'(sample_in);
                    m_pos++;
                    if (m_pos == len_tab[m_seg]) begin
                        e_done = 1'b1;
                        m_pos = 0;
                        if (auto_mode && ch_en != 4'd0) begin
                            nxt = m_seg;
                            for (int k = 4; k >= 1; k--) if (ch_en[(m_seg + k) % 4]) nxt = (m_seg + k) % 4;
                            m_seg = nxt;
                        end else begin
                            m_mode = 2;
                        end
                    end
                end
            end
            default: begin
                if (!arm) m_mode = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("wr_en", wr_en, e_wr_en);
        check("seg_done", seg_done, e_done);
        check("busy", busy, (m_mode == 1));
        check("active_ch", active_ch, m_seg);
        if (e_wr_en != 4'd0) begin
            check("wr_addr", wr_addr, e_addr);
            check("wr_data", wr_data, e_data);
        end
        if (seg_done) begin
            n_done++;
            done_log.push_back(int'(wr_en));
        end
        wr_mask |= wr_en;
        if (wr_en != 4'd0) addr_log.push_back(int'(wr_addr));
    endtask

    task automatic clear_tally();
        n_done = 0;
        wr_mask = 4'd0;
        addr_log.delete();
        done_log.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_active_ch"}, active_ch, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_seg_done"}, seg_done, 0);
    endtask

    initial begin
        clear_tally();
        // Power-on reset
        #1 reset_n = 1'b0;
        #1 check_zero("rst");
        tick();
        tick();
        check_zero("rst_hold");
        reset_n = 1'b1;
        tick();

        // Single segment 0, stop after one segment
        clear_tally();
        ch_en = 4'b0001; auto_mode = 1'b0; arm = 1'b1;
        tick();
        for (int i = 0; i < L0; i++) begin
            sample_valid = 1'b1; sample_in = 8'(i);
            tick();
        end
        sample_valid = 1'b0;
        tick();
        tick();
        check("s1_done_cnt", n_done, 1);
        check("s1_nwrites", addr_log.size(), L0);
        check("s1_last_addr", addr_log[L0-1], L0 - 1);
        check("s1_busy_hold", busy, 0);
        arm = 1'b0;
        tick();

        // All segments, auto advance
        clear_tally();
        ch_en = 4'b1111; auto_mode = 1'b1; arm = 1'b1;
        tick();
        for (int i = 0; i < L0 + L1 + L2 + L3; i++) begin
            sample_valid = 1'b1; sample_in = 8'($urandom);
            tick();
        end
        check("s2_done_cnt", n_done, 4);
        check("s2_seq0", done_log[0], 1);
        check("s2_seq1", done_log[1], 2);
        check("s2_seq2", done_log[2], 4);
        check("s2_seq3", done_log[3], 8);
        check("s2_wrap_ch", active_ch, 0);
        check("s2_busy", busy, 1);
        arm = 1'b0; sample_valid = 1'b0;
        tick();

        // Sparse enables 1 and 3
        clear_tally();
        ch_en = 4'b1010; auto_mode = 1'b1; arm = 1'b1;
        tick();
        for (int i = 0; i < L1 + L3 + L1; i++) begin
            sample_valid = 1'b1; sample_in = 8'($urandom);
            tick();
        end
        check("s3_done_cnt", n_done, 3);
        check("s3_seq0", done_log[0], 2);
        check("s3_seq1", done_log[1], 8);
        check("s3_seq2", done_log[2], 2);
        check("s3_mask_bit0_2", wr_mask & 4'b0101, 0);
        arm = 1'b0; sample_valid = 1'b0;
        tick();

        // Segment 2 with valid toggling every cycle
        clear_tally();
        ch_en = 4'b0100; auto_mode = 1'b0; arm = 1'b1;
        tick();
        for (int i = 0; i < 2 * L2; i++) begin
            sample_valid = (i % 2 == 0); sample_in = 8'($urandom);
            tick();
        end
        check("s4_nwrites", addr_log.size(), L2);
        for (int i = 0; i < L2; i++) check("s4_contig", addr_log[i], i);
        check("s4_done_cnt", n_done, 1);
        arm = 1'b0; sample_valid = 1'b0;
        tick();

        // Abort at address 50, then re-arm
        clear_tally();
        ch_en = 4'b0001; auto_mode = 1'b0; arm = 1'b1;
        tick();
        for (int i = 0; i <= 50; i++) begin
            sample_valid = 1'b1; sample_in = 8'(i);
            tick();
        end
        arm = 1'b0; sample_in = 8'd51;
        tick();
        check("s5_no_write51", wr_en, 0);
        check("s5_busy_off", busy, 0);
        check("s5_no_done", n_done, 0);
        arm = 1'b1; sample_valid = 1'b0;
        tick();
        sample_valid = 1'b1; sample_in = 8'hA5;
        tick();
        check("s5_restart_addr", wr_addr, 0);
        arm = 1'b0; sample_valid = 1'b0;
        tick();

        // Asynchronous reset in the middle of segment 3
        ch_en = 4'b1000; auto_mode = 1'b0; arm = 1'b1;
        tick();
        for (int i = 0; i <= 10; i++) begin
            sample_valid = 1'b1; sample_in = 8'(i + 100);
            tick();
        end
        #2 reset_n = 1'b0;
        #1 check_zero("s6_async");
        tick();
        tick();
        clear_tally();
        arm = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("s6_quiet", wr_mask, 0);
        arm = 1'b1; sample_valid = 1'b0;
        tick();
        sample_valid = 1'b1;
        tick();
        check("s6_rearm_addr", wr_addr, 0);
        check("s6_rearm_en", wr_en, 4'b1000);
        arm = 1'b0; sample_valid = 1'b0;
        tick();

        // Random traffic
        ch_en = 4'($urandom);
        auto_mode = 1'($urandom);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0) ch_en = 4'($urandom);
            if ($urandom_range(0, 99) == 0) auto_mode = ~auto_mode;
            arm = ($urandom_range(0, 63) != 0);
            sample_valid = ($urandom_range(0, 3) != 0);
            sample_in = 8'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
